// File: rtl/posit_add_pkg.sv
// Shared widths, clamp limits and the pipeline payload bundle for the posit adder
// normalisation stage.
package posit_add_pkg;

  localparam int N       = 32;
  localparam int ES      = 2;
  localparam int RS      = $clog2(N);
  localparam int SCALE_W = ES + RS + 1;
  localparam int LZ_W    = $clog2(N + 2);

  localparam logic signed [SCALE_W:0]   LE_ONE = (SCALE_W + 1)'(1);
  localparam logic signed [SCALE_W:0]   LE_MIN = (SCALE_W + 1)'(-((N - 2) << ES));
  localparam logic signed [SCALE_W:0]   LE_MAX = (SCALE_W + 1)'(((N - 2) << ES) + (1 << ES) - 1);
  localparam logic signed [SCALE_W-1:0] R_MAX  = SCALE_W'(N - 2);

  typedef struct packed {
    logic [N-1:0]               in1;
    logic [N-1:0]               in2;
    logic                       inf1;
    logic                       inf2;
    logic                       zero1;
    logic                       zero2;
    logic                       ls;
    logic signed [SCALE_W-1:0]  scale;
    logic [N:0]                 mant;
  } norm_bundle_t;

endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; reports W for an all-zero input.
module leading_zero_count #(
  parameter int W  = 33,
  parameter int CW = 6
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count
);

  // Ascending scan so the highest set bit is the last one to write the count.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/posit_add_normalise.sv
// Two-stage valid/ready normalisation of the posit adder sum: leading-one detect,
// mantissa left-normalise, scale adjust/clamp and regime/exponent split.
module posit_add_normalise
  import posit_add_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              IN1,
  input  logic [N-1:0]              IN2,
  input  logic signed [SCALE_W-1:0] LE_I,
  input  logic [N:0]                Add_Mant,
  input  logic                      LS_I,
  input  logic                      inf1,
  input  logic                      inf2,
  input  logic                      zero1,
  input  logic                      zero2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              IN1_O,
  output logic [N-1:0]              IN2_O,
  output logic signed [SCALE_W-1:0] LE_O,
  output logic [ES-1:0]             E_O,
  output logic [N-1:0]              Add_Mant_N,
  output logic signed [RS:0]        R_O,
  output logic                      LS,
  output logic                      inf1_O,
  output logic                      inf2_O,
  output logic                      zero1_O,
  output logic                      zero2_O,
  output logic                      sum_zero
);

  norm_bundle_t              s1_q, s1_d, s2_q, s2_d;
  logic                      s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [LZ_W-1:0]           lz_q, lz_d, lz_in;
  logic signed [RS:0]        r_q, r_d;
  logic                      s1_adv, s2_adv;

  logic                      sum_zero_c;
  logic [N-1:0]              mant_n;
  logic signed [SCALE_W:0]   le_wide;
  logic signed [SCALE_W-1:0] le_c, k, r_full;

  leading_zero_count #(.W(N + 1), .CW(LZ_W)) u_lzc (
    .din   (Add_Mant),
    .count (lz_in)
  );

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    lz_d       = lz_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.in1   = IN1;
        s1_d.in2   = IN2;
        s1_d.inf1  = inf1;
        s1_d.inf2  = inf2;
        s1_d.zero1 = zero1;
        s1_d.zero2 = zero2;
        s1_d.ls    = LS_I;
        s1_d.scale = LE_I;
        s1_d.mant  = Add_Mant;
        lz_d       = lz_in;
      end
    end
  end

  always_comb begin
    sum_zero_c = (s1_q.mant == '0);
    mant_n     = N'((s1_q.mant << lz_q) >> 1);
    le_wide    = $signed({s1_q.scale[SCALE_W-1], s1_q.scale}) + LE_ONE
                 - $signed({{(SCALE_W + 1 - LZ_W){1'b0}}, lz_q});
    if (le_wide < LE_MIN)      le_c = SCALE_W'(LE_MIN);
    else if (le_wide > LE_MAX) le_c = SCALE_W'(LE_MAX);
    else                       le_c = SCALE_W'(le_wide);
    if (sum_zero_c) le_c = '0;
    k = le_c >>> ES;
    // Negative regimes encode as -k-1, which is simply the bitwise inverse.
    r_full = (k < 0) ? ~k : k;
    if (r_full > R_MAX) r_full = R_MAX;

    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    r_d        = r_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d       = s1_q;
        s2_d.scale = le_c;
        // The spare low mantissa bit of the output bundle carries sum_zero.
        s2_d.mant  = {mant_n, sum_zero_c};
        r_d        = (RS + 1)'(r_full);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      lz_q       <= '0;
      r_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lz_q       <= lz_d;
      r_q        <= r_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign IN1_O      = s2_q.in1;
  assign IN2_O      = s2_q.in2;
  assign LE_O       = s2_q.scale;
  assign E_O        = s2_q.scale[ES-1:0];
  assign Add_Mant_N = s2_q.mant[N:1];
  assign sum_zero   = s2_q.mant[0];
  assign R_O        = r_q;
  assign LS         = s2_q.ls;
  assign inf1_O     = s2_q.inf1;
  assign inf2_O     = s2_q.inf2;
  assign zero1_O    = s2_q.zero1;
  assign zero2_O    = s2_q.zero2;

endmodule
